// File: rtl/falafel_fifo_hs.sv
// Synchronous valid/ready FIFO with arbitrary depth, occupancy count and almost flags.
// Define FALAFEL_FIFO_BYPASS_EN for a zero-latency pass-through path when empty.
module falafel_fifo_hs #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned AF_LEVEL = 56,
  parameter int unsigned AE_LEVEL = 8,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              almost_full_o,
  output logic              almost_empty_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic empty, full;
  logic push, pop;
  logic pass_through;
  logic store_push, store_pop;

  always_comb begin
    empty        = (count == '0);
    full         = (count == CNT_W'(DEPTH));
    in_ready_o   = !flush_i && !full;
    out_data_o   = mem[rd_ptr];
`ifdef FALAFEL_FIFO_BYPASS_EN
    out_valid_o  = !flush_i && (!empty || in_valid_i);
    if (empty && in_valid_i) begin
      out_data_o = in_data_i;
    end
`else
    out_valid_o  = !flush_i && !empty;
`endif
    push         = in_valid_i && in_ready_o;
    pop          = out_valid_o && out_ready_i;
`ifdef FALAFEL_FIFO_BYPASS_EN
    // An empty-FIFO push that is consumed at once never touches storage.
    pass_through = empty && push && pop;
`else
    pass_through = 1'b0;
`endif
    store_push   = push && !pass_through;
    store_pop    = pop && !pass_through;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store_push) begin
        mem[wr_ptr] <= in_data_i;
        wr_ptr      <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
      end
      if (store_pop) begin
        rd_ptr <= (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + ADDR_W'(1);
      end
      case ({store_push, store_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign count_o        = count;
  assign almost_full_o  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty_o = (count <= CNT_W'(AE_LEVEL));

endmodule

// File: tb/tb_falafel_fifo_hs.sv
// Directed bench for falafel_fifo_hs at DEPTH=5: vector table plus corner-case sequences.
module tb_falafel_fifo_hs;

  localparam int unsigned DEPTH  = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_i, flush_i, in_valid_i, out_ready_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o, out_valid_o, almost_full_o, almost_empty_o;
  logic [DATA_W-1:0] out_data_o;
  logic [CNT_W-1:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  falafel_fifo_hs #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .AF_LEVEL (4),
    .AE_LEVEL (1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .count_o        (count_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  // Inputs for this cycle plus the outputs expected before the next rising edge.
  typedef struct {
    logic        rst, flush, iv;
    logic [15:0] d;
    logic        ordy;
    int          cnt;
    logic        ir, ov;
    logic        dc;   // compare out_data only when set
    logic [15:0] od;
    logic        af, ae;
  } vec_t;

  function automatic vec_t v(input logic rst, flush, iv, input logic [15:0] d, input logic ordy,
                             input int cnt, input logic ir, ov, dc, input logic [15:0] od,
                             input logic af, ae);
    vec_t t;
    t.rst = rst; t.flush = flush; t.iv = iv; t.d = d; t.ordy = ordy;
    t.cnt = cnt; t.ir = ir; t.ov = ov; t.dc = dc; t.od = od; t.af = af; t.ae = ae;
    return t;
  endfunction

  task automatic check1(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    rst_i = t.rst; flush_i = t.flush; in_valid_i = t.iv; in_data_i = t.d; out_ready_i = t.ordy;
    #2;
    check1("count", idx, 32'(count_o), 32'(t.cnt));
    check1("in_ready", idx, 32'(in_ready_o), 32'(t.ir));
    check1("out_valid", idx, 32'(out_valid_o), 32'(t.ov));
    check1("almost_full", idx, 32'(almost_full_o), 32'(t.af));
    check1("almost_empty", idx, 32'(almost_empty_o), 32'(t.ae));
    if (t.dc) check1("out_data", idx, 32'(out_data_o), 32'(t.od));
  endtask

  vec_t        tbl [14];
  logic [15:0] q [$];

  initial begin
    // fill to full with consumer stalled, then drain
    tbl[0]  = v(0, 0, 1, 16'd1, 0, 0, 1, 0, 0, 16'd0, 0, 1);
    tbl[1]  = v(0, 0, 1, 16'd2, 0, 1, 1, 1, 1, 16'd1, 0, 1);
    tbl[2]  = v(0, 0, 1, 16'd3, 0, 2, 1, 1, 1, 16'd1, 0, 0);
    tbl[3]  = v(0, 0, 1, 16'd4, 0, 3, 1, 1, 1, 16'd1, 0, 0);
    tbl[4]  = v(0, 0, 1, 16'd5, 0, 4, 1, 1, 1, 16'd1, 1, 0);
    tbl[5]  = v(0, 0, 1, 16'd6, 0, 5, 0, 1, 1, 16'd1, 1, 0);
    tbl[6]  = v(0, 0, 1, 16'd6, 1, 5, 0, 1, 1, 16'd1, 1, 0);  // full: pop does not free a slot now
    tbl[7]  = v(0, 0, 0, 16'd0, 1, 4, 1, 1, 1, 16'd2, 1, 0);
    tbl[8]  = v(0, 0, 0, 16'd0, 1, 3, 1, 1, 1, 16'd3, 0, 0);
    tbl[9]  = v(0, 0, 0, 16'd0, 1, 2, 1, 1, 1, 16'd4, 0, 0);
    tbl[10] = v(0, 0, 0, 16'd0, 1, 1, 1, 1, 1, 16'd5, 0, 1);
    tbl[11] = v(0, 0, 0, 16'd0, 1, 0, 1, 0, 0, 16'd0, 0, 1);
    tbl[12] = v(0, 0, 1, 16'h10, 0, 0, 1, 0, 0, 16'd0, 0, 1);
    tbl[13] = v(0, 0, 1, 16'h11, 0, 1, 1, 1, 1, 16'h10, 0, 1);

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    apply(v(0, 0, 0, 16'd0, 0, 0, 1, 0, 1, 16'd0, 0, 1), 0);

    for (int i = 0; i < 14; i++) apply(tbl[i], 100 + i);

    // continuous streaming at count 2 across several pointer wraps
    q.push_back(16'h10);
    q.push_back(16'h11);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] exp_d;
      exp_d = q.pop_front();
      q.push_back(16'h20 + 16'(i));
      apply(v(0, 0, 1, 16'h20 + 16'(i), 1, 2, 1, 1, 1, exp_d, 0, 0), 200 + i);
    end

    // flush at count 3 with both handshakes requested
    apply(v(0, 0, 1, 16'h77, 0, 2, 1, 1, 1, q[0], 0, 0), 300);
    apply(v(0, 1, 1, 16'h88, 1, 3, 0, 0, 0, 16'd0, 0, 0), 301);
    apply(v(0, 0, 1, 16'hA5, 0, 0, 1, 0, 0, 16'd0, 0, 1), 302);
    apply(v(0, 0, 0, 16'd0, 1, 1, 1, 1, 1, 16'hA5, 0, 1), 303);
    apply(v(0, 0, 0, 16'd0, 0, 0, 1, 0, 0, 16'd0, 0, 1), 304);

    // push into an empty FIFO with consumer ready
`ifdef FALAFEL_FIFO_BYPASS_EN
    apply(v(0, 0, 1, 16'h3C, 1, 0, 1, 1, 1, 16'h3C, 0, 1), 400);
    apply(v(0, 0, 0, 16'd0, 1, 0, 1, 0, 0, 16'd0, 0, 1), 401);
`else
    apply(v(0, 0, 1, 16'h3C, 1, 0, 1, 0, 0, 16'd0, 0, 1), 400);
    apply(v(0, 0, 0, 16'd0, 1, 1, 1, 1, 1, 16'h3C, 0, 1), 401);
`endif
    apply(v(0, 0, 0, 16'd0, 0, 0, 1, 0, 0, 16'd0, 0, 1), 402);

    // reset mid-stream wins over a concurrent handshake
    apply(v(0, 0, 1, 16'h51, 0, 0, 1, 0, 0, 16'd0, 0, 1), 500);
    apply(v(0, 0, 1, 16'h52, 0, 1, 1, 1, 1, 16'h51, 0, 1), 501);
    apply(v(1, 0, 1, 16'h53, 1, 2, 1, 1, 1, 16'h51, 0, 0), 502);
    apply(v(0, 0, 0, 16'd0, 0, 0, 1, 0, 1, 16'd0, 0, 1), 503);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
